// File: rtl/ifetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory, the redirect source
// and the decode stage. The fetch unit connects through the master modport.
interface ifetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_misalign;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, fetch_misalign,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, fetch_misalign,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch unit: request -> wait for response -> hold for
// decode. Redirects replace the PC at any point; an in-flight response is then discarded.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_unit_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        kill_q, kill_d;
    logic        misalign_q, misalign_d;
    logic [31:0] target;

    assign target = {bus.redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= NOP;
            instr_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        misalign_d = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

        unique case (state_q)
            S_REQ: begin
                // A redirect coinciding with the handshake still issues the request,
                // so its response must be killed on return.
                if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                    kill_d  = bus.redirect_valid;
                end
                if (bus.redirect_valid) begin
                    pc_d = target;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    kill_d = 1'b0;
                    if (kill_q || bus.redirect_valid) begin
                        state_d = S_REQ;
                    end else begin
                        instr_d    = bus.imem_rsp_data;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    kill_d = 1'b1;
                end
                if (bus.redirect_valid) begin
                    pc_d = target;
                end
            end
            S_HOLD: begin
                // A redirect drops the held word even if decode accepts it this cycle.
                if (bus.redirect_valid) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (bus.instr_ready) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign bus.imem_req_valid = (state_q == S_REQ) && !rst;
    assign bus.imem_addr      = pc_q;
    assign bus.instr_valid    = (state_q == S_HOLD) && !rst;
    assign bus.instr          = instr_q;
    assign bus.instr_pc       = instr_pc_q;
    assign bus.fetch_misalign = misalign_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit: a memory responder and redirect source
// drive the DUT while the expected instruction stream is tracked as a queue of PCs.
module tb_ifetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          NCYC     = 3000;
    localparam int          IDEAL_LO = 3;
    localparam int          IDEAL_HI = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifetch_unit_if bus();

    ifetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks   = 0;
    int          n_err      = 0;
    int          n_consumed = 0;
    logic [31:0] exp_q[$];
    logic        exp_mis     = 1'b0;
    logic        outstanding = 1'b0;

    // Instruction memory contents: address 0 holds addi x1,x0,5.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0102;
            2:       return 32'hFFFF_FFF8;
            3:       return 32'hFFFF_FFFC;
            4:       return $urandom & 32'h0000_0FFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] exp_head();
        if (exp_q.size() == 0) return 32'hDEAD_BEEF;
        return exp_q[0];
    endfunction

    // Monitor: samples on the falling edge, pops the scoreboard on each accepted instruction.
    initial begin
        logic        m_req_stall;
        logic        m_hold_stall;
        logic [31:0] m_addr, m_instr, m_ipc, e;
        m_req_stall  = 1'b0;
        m_hold_stall = 1'b0;
        m_addr       = '0;
        m_instr      = '0;
        m_ipc        = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("req_valid_in_reset", 32'(bus.imem_req_valid), 32'd0);
                check("instr_valid_in_reset", 32'(bus.instr_valid), 32'd0);
            end else begin
                check("fetch_misalign", 32'(bus.fetch_misalign), 32'(exp_mis));
                if (bus.imem_req_valid) begin
                    check("imem_addr", bus.imem_addr, exp_head());
                    check("req_while_outstanding", 32'(outstanding), 32'd0);
                end
                if (m_req_stall) begin
                    check("req_valid_held", 32'(bus.imem_req_valid), 32'd1);
                    check("imem_addr_held", bus.imem_addr, m_addr);
                end
                if (m_hold_stall) begin
                    check("instr_valid_held", 32'(bus.instr_valid), 32'd1);
                    check("instr_held", bus.instr, m_instr);
                    check("instr_pc_held", bus.instr_pc, m_ipc);
                end
                if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
                    n_consumed++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL scoreboard_empty: got instr_pc %h, expected nothing at t=%0t",
                                 bus.instr_pc, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr_pc", bus.instr_pc, e);
                        check("instr", bus.instr, mem_word(e));
                        exp_q.push_back(e + 32'd4);
                    end
                end
            end
            m_req_stall  = !rst && bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect_valid;
            m_hold_stall = !rst && bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
            m_addr       = bus.imem_addr;
            m_instr      = bus.instr;
            m_ipc        = bus.instr_pc;
        end
    end

    // Stimulus: memory responder, redirect source, decode back-pressure and resets.
    initial begin
        logic        p_hs, p_rsp, p_rd, p_rst, ideal;
        logic [31:0] p_addr, p_rpc, out_addr;
        int          lat_cnt;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        out_addr           = '0;
        lat_cnt            = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            p_hs   = bus.imem_req_valid && bus.imem_req_ready;
            p_addr = bus.imem_addr;
            p_rsp  = bus.imem_rsp_valid;
            p_rd   = bus.redirect_valid;
            p_rpc  = bus.redirect_pc;
            p_rst  = rst;
            @(posedge clk);
            #1;
            // Reference model: what the edge just taken means architecturally.
            exp_mis = p_rd && !p_rst && (p_rpc[1:0] != 2'b00);
            if (p_rst) begin
                exp_q.delete();
                exp_q.push_back(RESET_PC);
                outstanding = 1'b0;
            end else begin
                if (p_rd) begin
                    exp_q.delete();
                    exp_q.push_back({p_rpc[31:2], 2'b00});
                end
                if (p_rsp && outstanding) outstanding = 1'b0;
                if (p_hs) begin
                    outstanding = 1'b1;
                    out_addr    = p_addr;
                    lat_cnt     = (c < IDEAL_HI) ? 0 : int'($urandom_range(0, 3));
                end
            end
            if (c == IDEAL_LO) n_consumed = 0;
            if (c == IDEAL_HI) check("zero_wait_throughput", 32'(n_consumed), 32'd10);

            ideal = (c >= IDEAL_LO) && (c < IDEAL_HI);
            if (c < IDEAL_LO) rst = 1'b1;
            else rst = !ideal && ($urandom_range(0, 199) == 0);

            if (outstanding) begin
                if (lat_cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_word(out_addr);
                end else begin
                    lat_cnt--;
                    bus.imem_rsp_valid = 1'b0;
                    bus.imem_rsp_data  = $urandom;
                end
            end else begin
                bus.imem_rsp_valid = !ideal && ($urandom_range(0, 4) == 0);
                bus.imem_rsp_data  = $urandom;
            end
            bus.imem_req_ready = ideal ? 1'b1 : ($urandom_range(0, 2) != 0);
            bus.instr_ready    = ideal ? 1'b1 : ($urandom_range(0, 1) == 0);
            if (!ideal && !rst && c >= IDEAL_LO && $urandom_range(0, 11) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = pick_target();
            end else begin
                bus.redirect_valid = 1'b0;
                bus.redirect_pc    = $urandom;
            end
        end
        @(negedge clk);
        check("instructions_delivered_min", 32'(n_consumed >= 100), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
